connection_neighbour_reader: RTL

- Read-side engine for the GAM connection memory. The connection memory writes edges during learning; this block reads them back.
- Given (class, node), it scans that node's adjacency row and streams out every connected neighbour with its age, under a valid/ready handshake.
- Used by the recall/association layer and by debug dumps.
- Drives a single-read-port, 1-cycle-latency lookup into the connection store.

---
 rtl/connection_neighbour_reader_if.sv | 36 +++
 rtl/connection_neighbour_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/connection_neighbour_reader_if.sv
// connection_neighbour_reader_if: request, connection-store read port and neighbour stream of the reader
interface connection_neighbour_reader_if #(
  parameter int NODE_COUNT  = 8,
  parameter int CLASS_COUNT = 4,
  parameter int AGE_W       = 8
);
  localparam int NW = $clog2(NODE_COUNT);
  localparam int CW = $clog2(CLASS_COUNT);
  logic             req_valid;
  logic             req_ready;
  logic [CW-1:0]    req_class;
  logic [NW-1:0]    req_node;
  logic             mem_rd_en;
  logic [CW-1:0]    mem_rd_class;
  logic [NW-1:0]    mem_rd_node1;
  logic [NW-1:0]    mem_rd_node2;
  logic             mem_rd_presence;
  logic [AGE_W-1:0] mem_rd_age;
  logic             nbr_valid;
  logic             nbr_ready;
  logic [NW-1:0]    nbr_node;
  logic [AGE_W-1:0] nbr_age;
  logic             done;
  logic [NW:0]      nbr_count;
  logic             req_err;
  modport master (
    input  req_valid, req_class, req_node, mem_rd_presence, mem_rd_age, nbr_ready,
    output req_ready, mem_rd_en, mem_rd_class, mem_rd_node1, mem_rd_node2,
           nbr_valid, nbr_node, nbr_age, done, nbr_count, req_err
  );
  modport slave (
    output req_valid, req_class, req_node, mem_rd_presence, mem_rd_age, nbr_ready,
    input  req_ready, mem_rd_en, mem_rd_class, mem_rd_node1, mem_rd_node2,
           nbr_valid, nbr_node, nbr_age, done, nbr_count, req_err
  );
endinterface

// File: rtl/connection_neighbour_reader.sv
// connection_neighbour_reader: scans one adjacency row of the connection store and streams its neighbours; CONN_AGE_FILTER_EN hides edges aged AGE_MAX or older
module connection_neighbour_reader #(
  parameter int NODE_COUNT  = 8,
  parameter int CLASS_COUNT = 4,
  parameter int AGE_W       = 8
`ifdef CONN_AGE_FILTER_EN
  ,
  parameter int AGE_MAX     = 20
`endif
) (
  input logic                          clk,
  input logic                          rst_n,
  connection_neighbour_reader_if.master io_bus
);
  localparam int NW = $clog2(NODE_COUNT);
  localparam int CW = $clog2(CLASS_COUNT);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [NW:0] N_LIM  = (NW+1)'(NODE_COUNT);
  localparam logic [CW:0] C_LIM  = (CW+1)'(CLASS_COUNT);
  localparam logic [NW:0] ONE    = (NW+1)'(1);
  localparam logic [NW:0] TWO    = (NW+1)'(2);
  logic [2:0]       r_state;
  logic [CW-1:0]    r_class;
  logic [NW-1:0]    r_node;
  logic [NW:0]      r_j;
  logic [NW:0]      r_count;
  logic             r_err;
  logic [NW-1:0]    r_nbr_node;
  logic [AGE_W-1:0] r_nbr_age;
  logic             w_idle;
  logic             w_accept;
  logic             w_illegal;
  logic [NW:0]      w_j_first;
  logic [NW:0]      w_j_inc;
  logic [NW:0]      w_j_adv;
  logic             w_adv_fin;
  logic             w_hit;
  assign w_idle    = rst_n && (r_state == S_IDLE);
  assign w_accept  = io_bus.req_valid && w_idle;
  assign w_illegal = (io_bus.req_class == '0) || ({1'b0, io_bus.req_class} >= C_LIM) ||
                     (io_bus.req_node == '0) || ({1'b0, io_bus.req_node} >= N_LIM);
  assign w_j_first = ({1'b0, io_bus.req_node} == ONE) ? TWO : ONE;
  // the candidate index steps over the diagonal so a node is never read against itself
  assign w_j_inc   = r_j + ONE;
  assign w_j_adv   = (w_j_inc == {1'b0, r_node}) ? r_j + TWO : w_j_inc;
  assign w_adv_fin = w_j_adv >= N_LIM;
`ifdef CONN_AGE_FILTER_EN
  localparam logic [AGE_W:0] AGE_LIM = (AGE_W+1)'(AGE_MAX);
  assign w_hit = io_bus.mem_rd_presence && ({1'b0, io_bus.mem_rd_age} < AGE_LIM);
`else
  assign w_hit = io_bus.mem_rd_presence;
`endif
  // scan FSM: accept, issue a read, check it one cycle later, emit hits, finish
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_class    <= '0;
      r_node     <= '0;
      r_j        <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_nbr_node <= '0;
      r_nbr_age  <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_class <= io_bus.req_class;
            r_node  <= io_bus.req_node;
            r_j     <= w_j_first;
            r_count <= '0;
            r_err   <= w_illegal;
            r_state <= (w_illegal || (w_j_first >= N_LIM)) ? S_FIN : S_ISSUE;
          end
        S_ISSUE: r_state <= S_CHECK;
        S_CHECK:
          if (w_hit) begin
            r_nbr_node <= r_j[NW-1:0];
            r_nbr_age  <= io_bus.mem_rd_age;
            r_count    <= r_count + ONE;
            r_state    <= S_EMIT;
          end else begin
            r_j     <= w_j_adv;
            r_state <= w_adv_fin ? S_FIN : S_ISSUE;
          end
        S_EMIT:
          if (io_bus.nbr_ready) begin
            r_j     <= w_j_adv;
            r_state <= w_adv_fin ? S_FIN : S_ISSUE;
          end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  assign io_bus.req_ready    = w_idle;
  assign io_bus.mem_rd_en    = r_state == S_ISSUE;
  assign io_bus.mem_rd_class = io_bus.mem_rd_en ? r_class : '0;
  assign io_bus.mem_rd_node1 = io_bus.mem_rd_en ? r_node : '0;
  assign io_bus.mem_rd_node2 = io_bus.mem_rd_en ? r_j[NW-1:0] : '0;
  assign io_bus.nbr_valid    = r_state == S_EMIT;
  assign io_bus.nbr_node     = io_bus.nbr_valid ? r_nbr_node : '0;
  assign io_bus.nbr_age      = io_bus.nbr_valid ? r_nbr_age : '0;
  assign io_bus.done         = r_state == S_FIN;
  assign io_bus.nbr_count    = io_bus.done ? r_count : '0;
  assign io_bus.req_err      = io_bus.done && r_err;
endmodule
